union_word_unpacker: RTL and testbench



---
 rtl/union_word_unpacker.sv | 94 +++++++++
 tb/tb_union_word_unpacker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/union_word_unpacker.sv
// union_word_unpacker: streaming word-to-byte unpacker.
// An accepted word is stored in a packed union (word view / byte-array view) and
// emitted one byte per output handshake, LSB-first or MSB-first.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - producer presents a word
//   in_ready  - block accepts a word this cycle (combinational from out_ready)
//   in_word   - word input, 8*NBYTES bits, written through the word view
//   out_valid - a byte is presented
//   out_ready - consumer takes the byte this cycle
//   out_byte  - current byte, read through the byte view
//   out_last  - high with the final byte of the current word
module union_word_unpacker #(
  parameter int unsigned NBYTES    = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_byte,
  output logic                  out_last
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

  // Byte i aliases word bits [8i+7:8i].
  typedef union packed {
    logic [8*NBYTES-1:0]     word;
    logic [NBYTES-1:0][7:0]  bytes;
  } store_u;

  typedef enum logic {StEmpty, StHold} state_e;

  state_e          r_state;
  store_u          r_store;
  logic [IW-1:0]   r_idx;

  logic            w_last;
  logic            w_in_acc;
  logic            w_out_acc;
  logic [IW-1:0]   w_sel;
  logic [7:0]      w_byte;

  assign w_last    = (r_idx == LastIdx);
  assign out_valid = (r_state == StHold);
  assign out_last  = out_valid && w_last;

  // A new word may enter while the final byte of the current one leaves.
  assign in_ready  = (r_state == StEmpty) || (out_ready && w_last);
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = out_valid && out_ready;

  assign w_sel = LSB_FIRST ? r_idx : (LastIdx - r_idx);

  // Explicit mux keeps the index width independent of NBYTES.
  always_comb begin
    w_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (w_sel == IW'(i)) begin
        w_byte = r_store.bytes[i];
      end
    end
  end

  assign out_byte = w_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StEmpty;
      r_store.word <= '0;
      r_idx        <= '0;
    end else if (w_in_acc) begin
      // Covers both the empty case and the back-to-back final-byte case.
      r_state      <= StHold;
      r_store.word <= in_word;
      r_idx        <= '0;
    end else if (w_out_acc) begin
      if (w_last) begin
        r_state <= StEmpty;
        r_idx   <= '0;
      end else begin
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_union_word_unpacker.sv
module tb_union_word_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_word;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_last;
  logic [7:0]  a_out_byte;
  logic        b_in_ready, b_out_valid, b_out_last;
  logic [7:0]  b_out_byte;

  logic        c_in_valid, c_out_ready;
  logic [7:0]  c_in_word;
  logic        c_in_ready, c_out_valid, c_out_last;
  logic [7:0]  c_out_byte;

  always #5 clk = ~clk;

  union_word_unpacker #(.NBYTES(4), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_word(in_word), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_byte(a_out_byte), .out_last(a_out_last)
  );

  union_word_unpacker #(.NBYTES(4), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_word(in_word), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_byte(b_out_byte), .out_last(b_out_last)
  );

  union_word_unpacker #(.NBYTES(1), .LSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_word(c_in_word), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_byte(c_out_byte), .out_last(c_out_last)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  logic [7:0] loga[$];
  logic [7:0] logb[$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
  endfunction

  // Reference: an accepted word becomes NBYTES queued bytes in emission order; one
  // word in flight, so the queue length is the number of bytes still to be emitted.
  function automatic void push_word(input logic [31:0] w);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.last = (i == 3);
      e.b    = w[8*i +: 8];
      qa.push_back(e);
      e.b    = w[8*(3-i) +: 8];
      qb.push_back(e);
    end
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    bit   ev_a, er_a, ev_b, er_b;
    exp_t e;
    if (rst_n) begin
      ev_a = (qa.size() != 0);
      er_a = (qa.size() == 0) || (out_ready && qa.size() == 1);
      ev_b = (qb.size() != 0);
      er_b = (qb.size() == 0) || (out_ready && qb.size() == 1);
      chk("a_out_valid", 32'(a_out_valid), 32'(ev_a));
      chk("a_in_ready", 32'(a_in_ready), 32'(er_a));
      chk("b_out_valid", 32'(b_out_valid), 32'(ev_b));
      chk("b_in_ready", 32'(b_in_ready), 32'(er_b));
      if (ev_a) begin
        e = qa[0];
        chk("a_out_byte", 32'(a_out_byte), 32'(e.b));
        chk("a_out_last", 32'(a_out_last), 32'(e.last));
        if (out_ready) begin
          loga.push_back(a_out_byte);
          void'(qa.pop_front());
        end
      end else begin
        chk("a_out_last_idle", 32'(a_out_last), 32'd0);
      end
      if (ev_b) begin
        e = qb[0];
        chk("b_out_byte", 32'(b_out_byte), 32'(e.b));
        chk("b_out_last", 32'(b_out_last), 32'(e.last));
        if (out_ready) begin
          logb.push_back(b_out_byte);
          void'(qb.pop_front());
        end
      end
      if (in_valid && er_a) push_word(in_word);
    end
  end

  task automatic step(input logic v, input logic [31:0] w, input logic r);
    in_valid  = v;
    in_word   = w;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    loga.delete();
    logb.delete();
  endtask

  // exp holds the expected bytes, first byte in the most significant position.
  task automatic check_log(input string nm, input logic [7:0] got[$],
                           input logic [63:0] exp, input int n);
    chk({nm, "_count"}, 32'(got.size()), 32'(n));
    for (int k = 0; k < n && k < got.size(); k++) begin
      chk(nm, 32'(got[k]), 32'(exp[8*(n-1-k) +: 8]));
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_word     = '0;
    out_ready   = 1'b0;
    c_in_valid  = 1'b0;
    c_in_word   = '0;
    c_out_ready = 1'b0;
    #1;
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_a_out_byte", 32'(a_out_byte), 32'd0);
    chk("rst_a_out_last", 32'(a_out_last), 32'd0);
    chk("rst_b_out_byte", 32'(b_out_byte), 32'd0);
    chk("rst_c_out_valid", 32'(c_out_valid), 32'd0);
    chk("rst_c_in_ready", 32'(c_in_ready), 32'd1);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // NBYTES=1: one byte per word, out_last follows out_valid.
    c_in_valid = 1'b1; c_in_word = 8'h5A; c_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("c_valid_1", 32'(c_out_valid), 32'd1);
    chk("c_byte_1", 32'(c_out_byte), 32'h5A);
    chk("c_last_1", 32'(c_out_last), 32'd1);
    chk("c_ready_1", 32'(c_in_ready), 32'd1);
    c_in_word = 8'hA5;
    @(posedge clk); #1;
    chk("c_valid_2", 32'(c_out_valid), 32'd1);
    chk("c_byte_2", 32'(c_out_byte), 32'hA5);
    chk("c_last_2", 32'(c_out_last), 32'd1);
    c_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("c_valid_3", 32'(c_out_valid), 32'd0);

    // Single word, no backpressure.
    clear_logs();
    step(1'b1, 32'hDEADBEEF, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    check_log("deadbeef_lsb", loga, 64'hEFBEADDE, 4);
    check_log("deadbeef_msb", logb, 64'hDEADBEEF, 4);

    // Back-to-back words, in_valid held until the second word is taken.
    clear_logs();
    step(1'b1, 32'h03020100, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h07060504, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    check_log("b2b_lsb", loga, 64'h0001020304050607, 8);

    // Backpressure; in_word changes while the word is held.
    clear_logs();
    step(1'b1, 32'h11223344, 1'b1);
    step(1'b0, 32'hFFFFFFFF, 1'b1);
    step(1'b0, 32'hFFFFFFFF, 1'b0);
    step(1'b0, 32'hFFFFFFFF, 1'b0);
    step(1'b0, 32'hFFFFFFFF, 1'b1);
    step(1'b0, 32'hFFFFFFFF, 1'b1);
    step(1'b0, 32'hFFFFFFFF, 1'b0);
    step(1'b0, 32'hFFFFFFFF, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check_log("bp_lsb", loga, 64'h44332211, 4);
    check_log("bp_msb", logb, 64'h11223344, 4);

    // Reset in the middle of a word.
    clear_logs();
    step(1'b1, 32'hCAFEF00D, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check_log("cafe_pre", loga, 64'h0D, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("midrst_b_out_valid", 32'(b_out_valid), 32'd0);
    chk("midrst_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("midrst_a_out_byte", 32'(a_out_byte), 32'd0);
    qa.delete();
    qb.delete();
    clear_logs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 32'h000000AA, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    check_log("postrst_lsb", loga, 64'hAA000000, 4);
    check_log("postrst_msb", logb, 64'h000000AA, 4);

    // Random traffic against the reference queues.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
    chk("drain_a_empty", 32'(qa.size()), 32'd0);
    chk("drain_b_empty", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
